memory_select: RTL and testbench
================================

# memory_select

Fetch/decode/execute address-select unit with an integrated synchronous RAM. A three-phase FDE sequencer drives a 4:1 address multiplexer. The selected address reads a registered-output RAM, so data for the current phase's address appears after the next clock edge. The unit sits between the core's address registers and its instruction/data memory.

## Interface
Parameters:
- ADDRESS_BITS, 5, width of every address input and of the RAM address (depth 2**ADDRESS_BITS)
- DATA_BITS, 8, RAM word width

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  sequencer advance enable
- w_enable  in  1  RAM write enable
- addr_a  in  ADDRESS_BITS  address selected in FETCH (state 0)
- addr_b  in  ADDRESS_BITS  address selected in DECODE (state 1)
- addr_c  in  ADDRESS_BITS  address selected in EXECUTE (state 2)
- addr_d  in  ADDRESS_BITS  address selected for state code 3 (reserved)
- data_in  in  DATA_BITS  RAM write data
- fde_state  out  2  current sequencer state code
- fetch, decode, execute  out  1 each  one-hot phase flags
- address  out  ADDRESS_BITS  mux output, driven to RAM
- data_out  out  DATA_BITS  registered RAM read data

## Operation
- Sequencer states: FETCH=2'd0, DECODE=2'd1, EXECUTE=2'd2.
  - When enable=1: FETCH→DECODE→EXECUTE→FETCH.
  - When enable=0: state holds.
  - Code 3 is unreachable. If entered, the next edge goes to FETCH regardless of enable.
- Phase flags are decoded combinationally from fde_state: exactly one high in states 0–2; all low in state 3.
- Address mux (combinational): fde_state 0/1/2/3 selects addr_a/addr_b/addr_c/addr_d.
- RAM: 2**ADDRESS_BITS words of DATA_BITS.
  - Every rising edge: data_out <= mem[address].
  - If w_enable=1 on that edge: mem[address] <= data_in.
  - Read-during-write is read-first: data_out gets the old word.
- Reset (rst_n=0, asynchronous):
  - fde_state=FETCH, fetch=1, decode=0, execute=0.
  - data_out=0.
  - address=addr_a.
  - RAM contents are not cleared. They are preloadable by the bench via hierarchical access to the memory array, named mem.
- After rst_n deasserts, the first rising edge acts normally.

## Timing
- Latency: data_out after edge N equals mem[address before edge N], i.e. the word of the phase active before that edge.
- With enable held high, data_out lags fde_state by exactly one phase. It shows the FETCH word while in DECODE, the DECODE word while in EXECUTE, and the EXECUTE word while in FETCH.
- enable low freezes fde_state and address. data_out keeps re-reading the same address each edge, so it reflects any write made to that address one edge later.
- Reset asserted mid-cycle forces outputs immediately, without waiting for a clock edge. The RAM write on the edge where rst_n=0 is suppressed.

## Structure
- Shared package memory_select_pkg holds:
  - state encoding constants FDE_FETCH, FDE_DECODE, FDE_EXECUTE, FDE_RSVD
  - default parameter values
- Sequencer and mux are small and live in the top module.
- One sub-module, memory_select_ram: the parameterized registered-read RAM. It owns the reset of data_out and write suppression under reset.

## Test plan
- Preload mem[0..3]=10,11,12,13; addr_a..d=0,1,2,3; enable=1, w_enable=0; release reset.
  - Required: data_out after successive edges = 10,11,12,10,11,12…
  - Required: fde_state = 1,2,0,1,2,0…
- enable=0 after two edges → fde_state stays 2, execute=1, address=2, data_out=12 every edge. enable=1 again → sequencing resumes at FETCH.
- w_enable=1, data_in=8'hA5 in DECODE with addr_b=1 → that edge's data_out=11 (read-first). Next edge, back in DECODE with enable=0 → data_out=8'hA5.
- Assert rst_n=0 between edges in EXECUTE → immediately fde_state=0, fetch=1, data_out=0. mem[] unchanged; re-reading mem[2] still gives 12.
- Force fde_state to 3 with addr_d=3 → address=3, all flags 0, next data_out=13, next state FETCH even with enable=0.
- Width check: ADDRESS_BITS=5; write to address 31 with data 8'hFF, read back 8'hFF; address 0 is unaffected.

Source files
------------

// File: rtl/memory_select_pkg.sv
// Shared definitions for the FDE address-select unit: phase encoding and default widths.
package memory_select_pkg;

   localparam int ADDRESS_BITS_DEF = 5;
   localparam int DATA_BITS_DEF    = 8;

   typedef enum logic [1:0] {
      FDE_FETCH   = 2'd0,
      FDE_DECODE  = 2'd1,
      FDE_EXECUTE = 2'd2,
      FDE_RSVD    = 2'd3
   } fde_state_t;

endpackage

// File: rtl/memory_select_ram.sv
// Single-port RAM with registered read, read-first on a same-address write.
// Latency: data_out shows mem[address] one edge after address is presented.
// Backpressure: none; a read and an optional write happen on every edge.
module memory_select_ram #(
   parameter int ADDRESS_BITS = memory_select_pkg::ADDRESS_BITS_DEF,
   parameter int DATA_BITS    = memory_select_pkg::DATA_BITS_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    w_enable,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [DATA_BITS-1:0]    data_in,
   output logic [DATA_BITS-1:0]    data_out
);

   localparam int DEPTH = 2 ** ADDRESS_BITS;

   logic [DATA_BITS-1:0] mem [DEPTH];

   // Contents survive reset; only the read register clears, and writes are
   // blocked on any edge seen while reset is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
      end else begin
         data_out <= mem[address];
         if (w_enable) begin
            mem[address] <= data_in;
         end
      end
   end

endmodule

// File: rtl/memory_select.sv
// Fetch/decode/execute sequencer driving a 4:1 address mux into a registered-read RAM.
// Latency: data_out carries the word for the phase that was active before the last edge.
// Backpressure: enable low freezes the phase; the RAM keeps re-reading the held address.
module memory_select
   import memory_select_pkg::*;
#(
   parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    w_enable,
   input  logic [ADDRESS_BITS-1:0] addr_a,
   input  logic [ADDRESS_BITS-1:0] addr_b,
   input  logic [ADDRESS_BITS-1:0] addr_c,
   input  logic [ADDRESS_BITS-1:0] addr_d,
   input  logic [DATA_BITS-1:0]    data_in,
   output logic [1:0]              fde_state,
   output logic                    fetch,
   output logic                    decode,
   output logic                    execute,
   output logic [ADDRESS_BITS-1:0] address,
   output logic [DATA_BITS-1:0]    data_out
);

   fde_state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FDE_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fetch     = 1'b0;
      decode    = 1'b0;
      execute   = 1'b0;
      address   = addr_a;
      case (state)
         FDE_FETCH: begin
            fetch   = 1'b1;
            address = addr_a;
            if (enable) state_nxt = FDE_DECODE;
         end
         FDE_DECODE: begin
            decode  = 1'b1;
            address = addr_b;
            if (enable) state_nxt = FDE_EXECUTE;
         end
         FDE_EXECUTE: begin
            execute = 1'b1;
            address = addr_c;
            if (enable) state_nxt = FDE_FETCH;
         end
         FDE_RSVD: begin
            // Unreachable code; recover to FETCH unconditionally.
            address   = addr_d;
            state_nxt = FDE_FETCH;
         end
      endcase
   end

   assign fde_state = state;

   memory_select_ram #(
      .ADDRESS_BITS (ADDRESS_BITS),
      .DATA_BITS    (DATA_BITS)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_enable (w_enable),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
   );

endmodule

// File: tb/tb_memory_select.sv
// Directed plus randomized check of memory_select against a phase/array reference model.
module tb_memory_select;
   import memory_select_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       w_enable;
   logic [4:0] addr_a, addr_b, addr_c, addr_d;
   logic [7:0] data_in;
   logic [1:0] fde_state;
   logic       fetch, decode, execute;
   logic [4:0] address;
   logic [7:0] data_out;

   memory_select dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .w_enable  (w_enable),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .addr_c    (addr_c),
      .addr_d    (addr_d),
      .data_in   (data_in),
      .fde_state (fde_state),
      .fetch     (fetch),
      .decode    (decode),
      .execute   (execute),
      .address   (address),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   // Reference model: phase number, memory image, last read word.
   int         ph;
   logic [7:0] rmem [32];
   logic [7:0] rdout;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [4:0] sel_addr(input int p);
      case (p)
         0:       return addr_a;
         1:       return addr_b;
         2:       return addr_c;
         default: return addr_d;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},   32'(fde_state), 32'(ph));
      check({tag, ".fetch"},   32'(fetch),     32'(ph == 0));
      check({tag, ".decode"},  32'(decode),    32'(ph == 1));
      check({tag, ".execute"}, 32'(execute),   32'(ph == 2));
      check({tag, ".address"}, 32'(address),   32'(sel_addr(ph)));
      check({tag, ".dout"},    32'(data_out),  32'(rdout));
   endtask

   task automatic model_edge();
      logic [4:0] a;
      if (!rst_n) begin
         ph    = 0;
         rdout = 8'h00;
      end else begin
         a     = sel_addr(ph);
         rdout = rmem[a];
         if (w_enable) rmem[a] = data_in;
         if (ph == 3)     ph = 0;
         else if (enable) ph = (ph + 1) % 3;
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      ph    = 0;
      rdout = 8'h00;
      #1 check_all(tag);
   endtask

   initial begin
      int exp_d [6];
      int exp_s [6];
      exp_d = '{10, 11, 12, 10, 11, 12};
      exp_s = '{1, 2, 0, 1, 2, 0};

      rst_n    = 1'b0;
      enable   = 1'b1;
      w_enable = 1'b0;
      addr_a   = 5'd0;
      addr_b   = 5'd1;
      addr_c   = 5'd2;
      addr_d   = 5'd3;
      data_in  = 8'h00;
      for (int i = 0; i < 32; i++) begin
         rmem[i] = (i < 4) ? 8'(10 + i) : 8'($urandom_range(0, 255));
         dut.u_ram.mem[i] = rmem[i];
      end
      ph    = 0;
      rdout = 8'h00;

      step("reset");
      rst_n = 1'b1;

      // Free-running sequence with the preloaded words.
      for (int i = 0; i < 6; i++) begin
         step("seq");
         check("seq.dout_const",  32'(data_out),  32'(exp_d[i]));
         check("seq.state_const", 32'(fde_state), 32'(exp_s[i]));
      end

      // Freeze in EXECUTE.
      step("adv");
      step("adv");
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("hold");
         check("hold.dout_const", 32'(data_out), 32'd12);
         check("hold.exec_const", 32'(execute),  32'd1);
      end
      enable = 1'b1;
      step("resume");
      check("resume.state_const", 32'(fde_state), 32'(FDE_FETCH));
      step("to_decode");

      // Read-first write in DECODE, then read back the new word.
      enable   = 1'b0;
      w_enable = 1'b1;
      data_in  = 8'hA5;
      step("wr");
      check("wr.readfirst", 32'(data_out), 32'd11);
      w_enable = 1'b0;
      step("wr_back");
      check("wr.readback", 32'(data_out), 32'hA5);

      // Asynchronous reset between edges while in EXECUTE; write under reset is dropped.
      enable = 1'b1;
      step("to_exec");
      async_reset("arst");
      check("arst.fetch_const", 32'(fetch), 32'd1);
      addr_a   = 5'd2;
      w_enable = 1'b1;
      data_in  = 8'h77;
      step("in_reset");
      rst_n    = 1'b1;
      w_enable = 1'b0;
      enable   = 1'b0;
      step("reread");
      check("reread.dout_const", 32'(data_out), 32'd12);

      // Reserved state code: flags low, addr_d selected, exits to FETCH with enable low.
      addr_a = 5'd0;
      force dut.state = FDE_RSVD;
      ph = 3;
      #1 check_all("rsvd");
      check("rsvd.addr_const", 32'(address), 32'd3);
      #3 release dut.state;
      step("rsvd_exit");
      check("rsvd.dout_const", 32'(data_out), 32'd13);

      // Top address of the array.
      addr_a   = 5'd31;
      w_enable = 1'b1;
      data_in  = 8'hFF;
      step("top_wr");
      w_enable = 1'b0;
      step("top_rd");
      check("top.dout_const", 32'(data_out), 32'hFF);
      addr_a = 5'd0;
      step("zero_rd");
      check("zero.dout_const", 32'(data_out), 32'd10);

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         rst_n    = 1'b1;
         enable   = ($urandom_range(0, 3) != 0);
         w_enable = ($urandom_range(0, 9) < 3);
         addr_a   = 5'($urandom_range(0, 31));
         addr_b   = 5'($urandom_range(0, 31));
         addr_c   = 5'($urandom_range(0, 31));
         addr_d   = 5'($urandom_range(0, 31));
         data_in  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 39) == 0) async_reset("rnd_arst");
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1);
   end

endmodule
